// File: rtl/disp_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
package disp_pkg;
  localparam int MAX_DIGITS      = 8;
  localparam int DEF_NUM_DIGITS  = 8;
  localparam int DEF_REFRESH_DIV = 100000;

  localparam logic [6:0]            SEG_BLANK = 7'h7F;
  localparam logic [MAX_DIGITS-1:0] AN_OFF    = '1;

  // Active-low one-hot anode select for a digit index.
  function automatic logic [MAX_DIGITS-1:0] an_sel(input logic [2:0] idx);
    an_sel = ~(MAX_DIGITS'(1) << idx);
  endfunction
endpackage

// File: rtl/display_scan_ctrl_seven_segment.sv
// SevenSegment: hex nibble to active-low segments, a..g on bits 6..0.
module SevenSegment (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = 7'h7F;
    endcase
  end
endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed common-anode seven-segment scanner with frame-aligned updates.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
  parameter int REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int CNT_W       = 17
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [4*NUM_DIGITS-1:0] val_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic                    frame_done,
  output logic                    pending
);

  logic [CNT_W-1:0]        prescaler;
  logic [2:0]              idx;
  logic                    tick;
  logic                    wrap;

  logic [4*NUM_DIGITS-1:0] act_val, pend_val;
  logic [NUM_DIGITS-1:0]   act_en, pend_en;
  logic [NUM_DIGITS-1:0]   act_dp, pend_dp;

  logic [3:0]              nib;
  logic                    en_bit;
  logic                    dp_bit;
  logic                    blank_bit;
  logic [6:0]              seg_dec;
  logic [MAX_DIGITS-1:0]   an_full;

  assign tick = (prescaler == CNT_W'(REFRESH_DIV - 1));
  assign wrap = tick && (idx == 3'(NUM_DIGITS - 1));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      prescaler  <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (tick) begin
        prescaler <= '0;
        idx       <= wrap ? 3'd0 : idx + 3'd1;
      end else begin
        prescaler <= prescaler + CNT_W'(1);
      end
    end
  end

  // A load landing on the wrap edge bypasses pending and drops any older pending value.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      act_val  <= '0;
      act_en   <= '0;
      act_dp   <= '0;
      pend_val <= '0;
      pend_en  <= '0;
      pend_dp  <= '0;
      pending  <= 1'b0;
    end else if (load && wrap) begin
      act_val <= val_in;
      act_en  <= digit_en_in;
      act_dp  <= dp_in;
      pending <= 1'b0;
    end else if (load) begin
      pend_val <= val_in;
      pend_en  <= digit_en_in;
      pend_dp  <= dp_in;
      pending  <= 1'b1;
    end else if (wrap && pending) begin
      act_val <= pend_val;
      act_en  <= pend_en;
      act_dp  <= pend_dp;
      pending <= 1'b0;
    end
  end

  always_comb begin
    nib    = 4'h0;
    en_bit = 1'b0;
    dp_bit = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == 3'(i)) begin
        nib    = act_val[i*4 +: 4];
        en_bit = act_en[i];
        dp_bit = act_dp[i];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz;

  // Disabled digits are transparent when deciding whether higher digits are all zero.
  always_comb begin
    logic higher_zero;
    lz          = '0;
    higher_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (act_en[i]) begin
        if (higher_zero && (act_val[i*4 +: 4] == 4'h0)) lz[i] = 1'b1;
        else higher_zero = 1'b0;
      end
    end
  end

  always_comb begin
    blank_bit = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == 3'(i)) blank_bit = lz[i];
    end
  end
`else
  assign blank_bit = 1'b0;
`endif

  SevenSegment u_dec (
    .hex (nib),
    .seg (seg_dec)
  );

  assign an_full = an_sel(idx);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      an_out  <= AN_OFF[NUM_DIGITS-1:0];
      seg_out <= SEG_BLANK;
      dp_out  <= 1'b1;
    end else if (!en_bit || (blank_bit && !dp_bit)) begin
      an_out  <= AN_OFF[NUM_DIGITS-1:0];
      seg_out <= SEG_BLANK;
      dp_out  <= 1'b1;
    end else if (blank_bit) begin
      an_out  <= an_full[NUM_DIGITS-1:0];
      seg_out <= SEG_BLANK;
      dp_out  <= 1'b0;
    end else begin
      an_out  <= an_full[NUM_DIGITS-1:0];
      seg_out <= seg_dec;
      dp_out  <= ~dp_bit;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl at NUM_DIGITS=8, REFRESH_DIV=4.
module tb_display_scan_ctrl;
  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] val_in;
  logic        load;
  logic [7:0]  digit_en_in;
  logic [7:0]  dp_in;
  logic [7:0]  an_out;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic        frame_done;
  logic        pending;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  display_scan_ctrl #(.NUM_DIGITS(8), .REFRESH_DIV(4), .CNT_W(2)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .val_in      (val_in),
    .load        (load),
    .digit_en_in (digit_en_in),
    .dp_in       (dp_in),
    .an_out      (an_out),
    .seg_out     (seg_out),
    .dp_out      (dp_out),
    .frame_done  (frame_done),
    .pending     (pending)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  function automatic logic [6:0] dec7(input logic [3:0] h);
    case (h)
      4'h0: dec7 = 7'b0000001;  4'h1: dec7 = 7'b1001111;
      4'h2: dec7 = 7'b0010010;  4'h3: dec7 = 7'b0000110;
      4'h4: dec7 = 7'b1001100;  4'h5: dec7 = 7'b0100100;
      4'h6: dec7 = 7'b0100000;  4'h7: dec7 = 7'b0001111;
      4'h8: dec7 = 7'b0000000;  4'h9: dec7 = 7'b0000100;
      4'hA: dec7 = 7'b0001000;  4'hB: dec7 = 7'b1100000;
      4'hC: dec7 = 7'b0110001;  4'hD: dec7 = 7'b1000010;
      4'hE: dec7 = 7'b0110000;  default: dec7 = 7'b0111000;
    endcase
  endfunction

  // Output after edge k shows slot ((k-1)/4)%8 of the value active before that edge.
  task automatic run_slots(input int n, input logic [31:0] v, input logic [7:0] en,
                           input logic [7:0] dp);
    int slot;
    logic [3:0] nib;
    logic [7:0] ea;
    logic [6:0] es;
    logic       ed;
    for (int j = 0; j < n; j++) begin
      step();
      slot = ((cyc - 1) / 4) % 8;
      nib  = 4'(v >> (slot * 4));
      if (en[slot]) begin
        ea = ~(8'h01 << slot);
        es = dec7(nib);
        ed = ~dp[slot];
      end else begin
        ea = 8'hFF;
        es = 7'h7F;
        ed = 1'b1;
      end
      chk("an_out", an_out, ea);
      chk("seg_out", seg_out, es);
      chk("dp_out", dp_out, ed);
      chk("frame_done", frame_done, (cyc % 32) == 0);
    end
  endtask

  task automatic do_load(input logic [31:0] v, input logic [7:0] en, input logic [7:0] dp);
    val_in      = v;
    digit_en_in = en;
    dp_in       = dp;
    load        = 1'b1;
  endtask

  initial begin
    Rst = 1'b1; load = 1'b0; val_in = '0; digit_en_in = '0; dp_in = '0;
    repeat (3) step();
    chk("rst_an", an_out, 8'hFF);
    chk("rst_seg", seg_out, 7'h7F);
    chk("rst_dp", dp_out, 1'b1);
    chk("rst_fd", frame_done, 1'b0);
    chk("rst_pend", pending, 1'b0);

    Rst = 1'b0;
    cyc = 0;
    do_load(32'h76543210, 8'hFF, 8'h00);
    step();
    load = 1'b0;
    chk("pend_first", pending, 1'b1);
    for (int j = 2; j <= 31; j++) begin
      step();
      chk("idle_an", an_out, 8'hFF);
      chk("idle_fd", frame_done, 1'b0);
    end
    step();
    chk("fd_first", frame_done, 1'b1);
    chk("pend_cleared", pending, 1'b0);
    run_slots(32, 32'h76543210, 8'hFF, 8'h00);

    run_slots(5, 32'h76543210, 8'hFF, 8'h00);
    do_load(32'h88888888, 8'hFF, 8'h00);
    run_slots(1, 32'h76543210, 8'hFF, 8'h00);
    load = 1'b0;
    chk("pend_mid", pending, 1'b1);
    run_slots(26, 32'h76543210, 8'hFF, 8'h00);
    chk("pend_after_wrap", pending, 1'b0);
    run_slots(31, 32'h88888888, 8'hFF, 8'h00);

    do_load(32'hABCDEF01, 8'hFF, 8'h00);
    run_slots(1, 32'h88888888, 8'hFF, 8'h00);
    load = 1'b0;
    chk("pend_coinc", pending, 1'b0);
    run_slots(31, 32'hABCDEF01, 8'hFF, 8'h00);

    do_load(32'h76543210, 8'h0F, 8'h02);
    run_slots(1, 32'hABCDEF01, 8'hFF, 8'h00);
    load = 1'b0;
    chk("pend_coinc2", pending, 1'b0);
    run_slots(31, 32'h76543210, 8'h0F, 8'h02);

    do_load(32'h00000305, 8'hFF, 8'h00);
    run_slots(1, 32'h76543210, 8'h0F, 8'h02);
    load = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    for (int j = 0; j < 32; j++) begin
      int slot;
      logic [7:0] ea;
      logic [6:0] es;
      step();
      slot = ((cyc - 1) / 4) % 8;
      if (slot >= 3) begin ea = 8'hFF; es = 7'h7F; end
      else begin
        ea = ~(8'h01 << slot);
        es = (slot == 2) ? 7'b0000110 : (slot == 1) ? 7'b0000001 : 7'b0100100;
      end
      chk("lzb_an", an_out, ea);
      chk("lzb_seg", seg_out, es);
      chk("lzb_dp", dp_out, 1'b1);
    end
`else
    run_slots(32, 32'h00000305, 8'hFF, 8'h00);
`endif

    repeat (5) step();
    do_load(32'h11111111, 8'hFF, 8'hFF);
    step();
    load = 1'b0;
    chk("pend_before_rst", pending, 1'b1);
    repeat (3) step();
    Rst = 1'b1;
    do_load(32'h22222222, 8'hFF, 8'h00);
    step();
    load = 1'b0;
    chk("midrst_pend", pending, 1'b0);
    chk("midrst_an", an_out, 8'hFF);
    chk("midrst_seg", seg_out, 7'h7F);
    chk("midrst_dp", dp_out, 1'b1);
    chk("midrst_fd", frame_done, 1'b0);

    Rst = 1'b0;
    cyc = 0;
    do_load(32'h00000001, 8'h01, 8'h00);
    step();
    load = 1'b0;
    chk("post_rst_pend", pending, 1'b1);
    for (int j = 2; j <= 31; j++) begin
      step();
      chk("post_rst_fd", frame_done, 1'b0);
      chk("post_rst_an", an_out, 8'hFF);
    end
    step();
    chk("post_rst_wrap_fd", frame_done, 1'b1);
    chk("post_rst_wrap_pend", pending, 1'b0);
    step();
    chk("post_rst_an0", an_out, 8'hFE);
    chk("post_rst_seg0", seg_out, 7'b1001111);
    chk("post_rst_dp0", dp_out, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
